// File: rtl/uart_rx_packer_pkg.sv
// Shared types and helpers for the UART receive path and its word packer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Clocks per oversample tick, truncated toward zero.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_packer_if.sv
// Output bundle of the receiver: byte status plus the packed-word write port.
interface uart_rx_packer_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 16
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              frame_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output byte_data, byte_valid, frame_err,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input byte_data, byte_valid, frame_err,
    input wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/uart_rx_packer_rx_byte.sv
// Byte receiver: rx synchroniser, oversample tick generator and framing FSM
// with 3-sample majority voting at each bit centre.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  input  logic       i_clr,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_C0   = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_C1   = SMP_W'(OVERSAMPLE / 2);
  localparam logic [SMP_W-1:0] SMP_C2   = SMP_W'(OVERSAMPLE / 2 + 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_byte: OVERSAMPLE must be even and at least 8");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_byte: CLK_HZ too low for BAUD*OVERSAMPLE");
  end

  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic [SMP_W-1:0] r_smp_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_smp0;
  logic             r_smp1;
  rx_state_t        r_state;

  logic w_tick;
  logic w_start_edge;
  logic w_vote;

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_start_edge = (r_state == IDLE) && r_rx_prev && !r_rx_s2;
  // Third sample is the live synchronised value at the vote tick.
  assign w_vote       = maj3(r_smp0, r_smp1, r_rx_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Restarting on the start edge phase-aligns every later tick to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_start_edge || i_clr || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_smp_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_smp0       <= 1'b1;
      r_smp1       <= 1'b1;
      o_byte_data  <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (i_clr) begin
        r_state   <= IDLE;
        r_smp_cnt <= '0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_edge) begin
              r_state   <= START;
              r_smp_cnt <= '0;
            end
          end
          default: begin
            if (w_tick) begin
              r_smp_cnt <= (r_smp_cnt == SMP_LAST) ? '0 : r_smp_cnt + 1'b1;
              if (r_smp_cnt == SMP_C0) r_smp0 <= r_rx_s2;
              if (r_smp_cnt == SMP_C1) r_smp1 <= r_rx_s2;
              if (r_smp_cnt == SMP_C2) begin
                case (r_state)
                  START: begin
                    r_bit_cnt <= '0;
                    r_state   <= w_vote ? IDLE : DATA;
                  end
                  DATA: begin
                    r_shift   <= {w_vote, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_state <= STOP;
                  end
                  STOP: begin
                    if (w_vote) begin
                      o_byte_valid <= 1'b1;
                      o_byte_data  <= r_shift;
                    end else begin
                      o_frame_err  <= 1'b1;
                    end
                    r_state <= IDLE;
                  end
                  default: r_state <= IDLE;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// UART receiver feeding a byte-group packer that writes fixed-width words
// to an auto-incrementing address, most-significant word first.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int BAUD            = 9600,
  parameter int OVERSAMPLE      = 16,
  parameter int WORD_W          = 12,
  parameter int GROUP_BYTES     = 3,
  parameter int WORDS_PER_GROUP = 2,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rx,
  input  logic              i_clr,
  uart_rx_packer_if.master  o_if
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int GRP_W = GROUP_BYTES * 8;
  localparam int BC_W  = (GROUP_BYTES > 1) ? $clog2(GROUP_BYTES) : 1;
  localparam int WI_W  = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(GROUP_BYTES - 1);
  localparam logic [WI_W-1:0] WI_LAST = WI_W'(WORDS_PER_GROUP - 1);

  if (GROUP_BYTES * 8 != WORDS_PER_GROUP * WORD_W) begin : g_bad_pack
    $error("uart_rx_packer: GROUP_BYTES*8 must equal WORDS_PER_GROUP*WORD_W");
  end
  if (WORDS_PER_GROUP >= DIV * OVERSAMPLE) begin : g_bad_emit
    $error("uart_rx_packer: word emission would overlap the next byte");
  end

  logic [7:0] w_byte_data;
  logic       w_byte_valid;
  logic       w_frame_err;

  uart_rx_byte #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (i_rx),
    .i_clr        (i_clr),
    .o_byte_data  (w_byte_data),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  logic [GRP_W-1:0]  r_group;
  logic [BC_W-1:0]   r_bcnt;
  logic [WI_W-1:0]   r_widx;
  logic              r_emit;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic [GRP_W-1:0]  w_group_next;

  assign w_group_next = (r_group << 8) | GRP_W'(w_byte_data);

  // Word k counted from the most-significant end of the group.
  function automatic logic [WORD_W-1:0] word_at(input logic [GRP_W-1:0] g,
                                                input logic [WI_W-1:0]  k);
    return WORD_W'(g >> (GRP_W - (int'(k) + 1) * WORD_W));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_group   <= '0;
      r_bcnt    <= '0;
      r_widx    <= '0;
      r_emit    <= 1'b0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (i_clr) begin
      r_bcnt  <= '0;
      r_widx  <= '0;
      r_emit  <= 1'b0;
      r_addr  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_byte_valid) begin
        r_group <= w_group_next;
        if (r_bcnt == BC_LAST) begin
          // First word goes out the cycle after the closing byte.
          r_bcnt    <= '0;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= word_at(w_group_next, '0);
          r_addr    <= r_addr + 1'b1;
          r_widx    <= WI_W'(1);
          r_emit    <= (WORDS_PER_GROUP > 1);
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end else if (w_frame_err) begin
        r_bcnt <= '0;
      end else if (r_emit) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr;
        r_wr_data <= word_at(r_group, r_widx);
        r_addr    <= r_addr + 1'b1;
        r_widx    <= r_widx + 1'b1;
        if (r_widx == WI_LAST) r_emit <= 1'b0;
      end
    end
  end

  assign o_if.byte_data  = w_byte_data;
  assign o_if.byte_valid = w_byte_valid;
  assign o_if.frame_err  = w_frame_err;
  assign o_if.wr_en      = r_wr_en;
  assign o_if.wr_addr    = r_wr_addr;
  assign o_if.wr_data    = r_wr_data;

endmodule

// File: doc/uart_rx_packer.md
# uart_rx_packer

Parametrised UART receive path with 16x oversampling, majority-vote bit sampling, start-glitch rejection and stop-bit framing checks. Received bytes are packed into fixed-width words and written out through a simple write port with an auto-incrementing address. It sits between the board RX pin and the note/score memory loader. It is the generalised successor of the fixed 9600-baud, 3-byte-to-two-12-bit-word receiver.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 9600, line rate
- OVERSAMPLE, 16, samples per bit; even, ≥ 8
- WORD_W, 12, width of packed output word
- GROUP_BYTES, 3, bytes collected per packing group
- WORDS_PER_GROUP, 2, words emitted per group; must satisfy GROUP_BYTES*8 == WORDS_PER_GROUP*WORD_W, checked at elaboration
- ADDR_W, 16, write address width
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rx  in  1  serial line, asynchronous, idle high
- clr  in  1  synchronous clear: address, group and receiver return to start
- byte_data  out  8  last good byte; holds until the next good byte
- byte_valid  out  1  one-cycle pulse per good byte
- frame_err  out  1  one-cycle pulse per byte with a bad stop bit
- wr_en  out  1  one-cycle write strobe per word
- wr_addr  out  ADDR_W  word address, valid with wr_en
- wr_data  out  WORD_W  word data, valid with wr_en

## Operation
- rx passes through a 2-flop synchroniser reset to 1. All decisions use the synchronised value.
- Tick generator: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer, truncated. Emits a one-cycle tick every DIV clocks. It restarts at 0 on a start-edge detection.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: a high-to-low transition of the synchronised rx goes to START, with the sample counter at 0.
  - START: samples OVERSAMPLE/2-1, /2 and /2+1 are taken on ticks; the majority vote is taken at /2+1. If the majority is 1, it is a false start and the FSM returns to IDLE with no pulse. If 0, it goes to DATA.
  - DATA: 8 bits, LSB first. Each bit uses the same 3-sample majority at the bit centre. The sample counter wraps at OVERSAMPLE-1.
  - STOP: 3-sample majority at the centre. If 1, pulse byte_valid and update byte_data. If 0, pulse frame_err. In both cases go to IDLE immediately after the vote, without waiting for the end of the stop bit.
- Packer:
  - A shift register GROUP_BYTES*8 wide; each good byte shifts in at the LSB end. A byte counter runs 0..GROUP_BYTES-1.
  - On the last byte of a group, emit WORDS_PER_GROUP words, most-significant word first. Example defaults: bytes AB,CD,EF give ABC then DEF.
  - frame_err discards the partial group: byte counter to 0, shift register unchanged.
- Address:
  - The first write after reset or clr uses address 0.
  - The address post-increments after every wr_en.
  - It wraps modulo 2^ADDR_W silently.
- clr:
  - Aborts any frame (FSM to IDLE, no pulses) and zeroes the byte counter and address.
  - Stops an in-progress word emission from the next cycle.
  - If clr and a byte_valid-generating vote occur in the same cycle, clr wins and nothing is output.

## Timing
- Reset values:
  - byte_data 0, byte_valid 0, frame_err 0
  - wr_en 0, wr_addr 0, wr_data 0
  - FSM IDLE, synchroniser 1s
- Synchroniser latency is 2 clk. Start detection is 1 clk after the synchronised edge.
- byte_valid and frame_err rise 1 clk after the stop-bit vote tick.
- wr_en for word k (k = 0..WORDS_PER_GROUP-1) is asserted in cycle N+1+k, where N is the cycle of the last byte's byte_valid. The words are back-to-back, and wr_addr/wr_data are stable during each wr_en.
- Emission never overlaps the next byte, since WORDS_PER_GROUP < DIV*OVERSAMPLE. Elaboration asserts this.
- rst_n asserted mid-frame or mid-emission forces all reset values asynchronously. The first edge after release is treated as a new start.

## Structure
- Package uart_pkg:
  - receiver state enum (IDLE/START/DATA/STOP)
  - majority-of-3 function
  - DIV computation as a function of CLK_HZ, BAUD, OVERSAMPLE
- Sub-module uart_rx_byte:
  - contains the synchroniser, tick generator and receiver FSM
  - outputs byte_data, byte_valid, frame_err
  - takes clr as abort
- The top level instantiates uart_rx_byte and holds the packer and address logic.

## Test plan
Unless a scenario states otherwise, use CLK_HZ=1_600_000, BAUD=10_000 (DIV=10) and the other defaults.
- Frame 0x55 with a good stop bit -> one byte_valid, byte_data=0x55, frame_err stays 0, no wr_en.
- Bytes 0xAB, 0xCD, 0xEF -> wr_en at N+1 (addr 0, data 0xABC) and N+2 (addr 1, data 0xDEF), then wr_en 0.
- Byte 0x12 sent with stop bit 0, then 0x01, 0x23, 0x45 -> frame_err pulse with no byte_valid for 0x12; writes 0x012 at addr 0 and 0x345 at addr 1.
- rx low for 50 clk (< half-bit), then high -> no byte_valid, no frame_err, FSM back in IDLE.
- ADDR_W=2, 3 groups -> wr_addr sequence 0,1,2,3,0,1.
- clr pulsed mid-DATA, then one full group -> no pulses from the aborted frame; writes start at addr 0. Repeat the scenario using rst_n instead of clr -> same result, and all outputs are 0 during reset.
